// File: rtl/gf180mcu_ws_io__ring_seq.sv
// IO-ring power sequencer: syncs and debounces supply-good flags, ramps pad-group
// enables up one group at a time, ramps them down in reverse, and latches supply-drop faults.
module gf180mcu_ws_io__ring_seq #(
    parameter int DEB_CYCLES = 64,
    parameter int STAGE_GAP  = 16,
    parameter int N_GRP      = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             DVDD_OK,
    input  logic             VDD_OK,
    input  logic             REQ_OFF,
    input  logic             FAULT_CLR,
    output logic [N_GRP-1:0] GRP_EN,
    output logic             RDY,
    output logic             OFF_ACK,
    output logic             FAULT,
    output logic [2:0]       STATE
);

    localparam int CNT_MAX = (DEB_CYCLES > STAGE_GAP) ? DEB_CYCLES : STAGE_GAP;
    localparam int CW      = $clog2(CNT_MAX) + 1;

    localparam logic [CW-1:0]    DEB_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0]    GAP_LAST = CW'(STAGE_GAP - 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [N_GRP-1:0] GRP_ONE  = N_GRP'(1);
    localparam logic [N_GRP-1:0] GRP_ALL  = '1;

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_DEB    = 3'd1,
        S_RAMP   = 3'd2,
        S_ON     = 3'd3,
        S_RAMPDN = 3'd4,
        S_FLT    = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_GRP-1:0]  grp_q, grp_d;
    logic              rdy_q, rdy_d;
    logic              ack_q, ack_d;
    logic              fault_q, fault_d;
    logic              dvddMeta_q, dvddSync_q, vddMeta_q, vddSync_q;
    logic              ok;
    logic              poweredState;
    logic [CW-1:0]     cntInc;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dvddMeta_q <= 1'b0;
            dvddSync_q <= 1'b0;
            vddMeta_q  <= 1'b0;
            vddSync_q  <= 1'b0;
        end else begin
            dvddMeta_q <= DVDD_OK;
            dvddSync_q <= dvddMeta_q;
            vddMeta_q  <= VDD_OK;
            vddSync_q  <= vddMeta_q;
        end
    end

    assign ok           = dvddSync_q & vddSync_q;
    assign poweredState = (state_q == S_RAMP) || (state_q == S_ON) || (state_q == S_RAMPDN);
    assign cntInc       = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_OFF;
            cnt_q   <= '0;
            grp_q   <= '0;
            rdy_q   <= 1'b0;
            ack_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grp_q   <= grp_d;
            rdy_q   <= rdy_d;
            ack_q   <= ack_d;
            fault_q <= fault_d;
        end
    end

    // A supply drop while any group may be live overrides every other request.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grp_d   = grp_q;
        rdy_d   = rdy_q;
        ack_d   = 1'b0;
        fault_d = fault_q;
        if (poweredState && !ok) begin
            state_d = S_FLT;
            cnt_d   = '0;
            grp_d   = '0;
            rdy_d   = 1'b0;
            fault_d = 1'b1;
        end else begin
            case (state_q)
                S_OFF: begin
                    cnt_d = '0;
                    if (ok && !REQ_OFF) begin
                        state_d = S_DEB;
                        cnt_d   = CNT_ONE;
                    end
                end
                S_DEB: begin
                    if (!ok || REQ_OFF) begin
                        state_d = S_OFF;
                        cnt_d   = '0;
                    end else if (cnt_q >= DEB_LAST) begin
                        state_d = S_RAMP;
                        cnt_d   = '0;
                        grp_d   = GRP_ONE;
                    end else begin
                        cnt_d = cntInc;
                    end
                end
                S_RAMP: begin
                    if (REQ_OFF) begin
                        state_d = S_RAMPDN;
                        cnt_d   = '0;
                    end else if (cnt_q >= GAP_LAST) begin
                        cnt_d = '0;
                        if (grp_q == GRP_ALL) begin
                            state_d = S_ON;
                            rdy_d   = 1'b1;
                        end else begin
                            grp_d = (grp_q << 1) | GRP_ONE;
                        end
                    end else begin
                        cnt_d = cntInc;
                    end
                end
                S_ON: begin
                    if (REQ_OFF) begin
                        state_d = S_RAMPDN;
                        cnt_d   = '0;
                        rdy_d   = 1'b0;
                    end
                end
                S_RAMPDN: begin
                    if (grp_q == '0) begin
                        state_d = S_OFF;
                        cnt_d   = '0;
                        ack_d   = 1'b1;
                    end else if (cnt_q >= GAP_LAST) begin
                        cnt_d = '0;
                        grp_d = grp_q >> 1;
                    end else begin
                        cnt_d = cntInc;
                    end
                end
                S_FLT: begin
                    grp_d   = '0;
                    rdy_d   = 1'b0;
                    fault_d = 1'b1;
                    if (FAULT_CLR) begin
                        state_d = S_OFF;
                        cnt_d   = '0;
                        fault_d = 1'b0;
                    end
                end
                default: begin
                    state_d = S_FLT;
                    cnt_d   = '0;
                    grp_d   = '0;
                    rdy_d   = 1'b0;
                    fault_d = 1'b1;
                end
            endcase
        end
    end

    assign GRP_EN  = grp_q;
    assign RDY     = rdy_q;
    assign OFF_ACK = ack_q;
    assign FAULT   = fault_q;
    assign STATE   = state_q;

endmodule

// File: tb/tb_gf180mcu_ws_io__ring_seq.sv
// Directed power-sequencing scenarios with randomized timing, checked against
// closed-form expectations for ramp-up, ramp-down, debounce and fault behaviour.
module tb_gf180mcu_ws_io__ring_seq;

    localparam int DEB  = 4;
    localparam int GAP  = 2;
    localparam int NG   = 4;
    localparam int SYNC = 2;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       DVDD_OK = 1'b0;
    logic       VDD_OK = 1'b0;
    logic       REQ_OFF = 1'b0;
    logic       FAULT_CLR = 1'b0;

    logic [3:0] grpA;
    logic       rdyA, ackA, fltA;
    logic [2:0] stA;
    logic [0:0] grpB;
    logic       rdyB, ackB, fltB;
    logic [2:0] stB;

    int nAsserts = 0;
    int nFail = 0;

    always #5 CLK = ~CLK;

    gf180mcu_ws_io__ring_seq #(.DEB_CYCLES(DEB), .STAGE_GAP(GAP), .N_GRP(NG)) dutA (
        .CLK(CLK), .RST(RST), .DVDD_OK(DVDD_OK), .VDD_OK(VDD_OK),
        .REQ_OFF(REQ_OFF), .FAULT_CLR(FAULT_CLR),
        .GRP_EN(grpA), .RDY(rdyA), .OFF_ACK(ackA), .FAULT(fltA), .STATE(stA)
    );

    gf180mcu_ws_io__ring_seq #(.DEB_CYCLES(DEB), .STAGE_GAP(1), .N_GRP(1)) dutB (
        .CLK(CLK), .RST(RST), .DVDD_OK(DVDD_OK), .VDD_OK(VDD_OK),
        .REQ_OFF(REQ_OFF), .FAULT_CLR(FAULT_CLR),
        .GRP_EN(grpB), .RDY(rdyB), .OFF_ACK(ackB), .FAULT(fltB), .STATE(stB)
    );

    // Number of enabled groups n edges after ramp start, and during ramp-down.
    function automatic int upLevel(input int n, input int gap, input int ng);
        int l;
        l = 1 + n / gap;
        return (l > ng) ? ng : l;
    endfunction

    function automatic int dnLevel(input int lvl, input int m, input int gap);
        int l;
        l = lvl - m / gap;
        return (l < 0) ? 0 : l;
    endfunction

    function automatic logic [31:0] therm(input int l);
        return (32'd1 << l) - 32'd1;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic dvdd, input logic vdd, input logic req, input logic clr);
        DVDD_OK   = dvdd;
        VDD_OK    = vdd;
        REQ_OFF   = req;
        FAULT_CLR = clr;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag, input int sel, input int st, input int lvl,
                            input logic rdy, input logic ack, input logic flt);
        if (sel == 0) begin
            checkOutput({tag, ".state"}, 32'(stA), 32'(st));
            checkOutput({tag, ".grp"}, 32'(grpA), therm(lvl));
            checkOutput({tag, ".rdy"}, 32'(rdyA), 32'(rdy));
            checkOutput({tag, ".ack"}, 32'(ackA), 32'(ack));
            checkOutput({tag, ".fault"}, 32'(fltA), 32'(flt));
        end else begin
            checkOutput({tag, ".state"}, 32'(stB), 32'(st));
            checkOutput({tag, ".grp"}, 32'(grpB), therm(lvl));
            checkOutput({tag, ".rdy"}, 32'(rdyB), 32'(rdy));
            checkOutput({tag, ".ack"}, 32'(ackB), 32'(ack));
            checkOutput({tag, ".fault"}, 32'(fltB), 32'(flt));
        end
    endtask

    // Called right after the edge that entered RAMP; ends one edge after ON.
    task automatic rampWalk(input int sel, input int gap, input int ng);
        for (int n = 0; n <= ng * gap + 1; n++) begin
            if (n > 0) tick();
            checkAll($sformatf("ramp%0d.n%0d", sel, n), sel, (n >= ng * gap) ? 3 : 2,
                     upLevel(n, gap, ng), (n >= ng * gap), 1'b0, 1'b0);
        end
    endtask

    // REQ_OFF must already be set; first tick is the edge that enters RAMPDN.
    task automatic rampDownWalk(input int sel, input int lvl, input int gap,
                                input bit dropReq, input int stAfter);
        for (int m = 0; m <= lvl * gap + 2; m++) begin
            tick();
            if (m <= lvl * gap)
                checkAll($sformatf("dn%0d.m%0d", sel, m), sel, 4, dnLevel(lvl, m, gap), 1'b0, 1'b0, 1'b0);
            else if (m == lvl * gap + 1)
                checkAll($sformatf("dn%0d.ack", sel), sel, 0, 0, 1'b0, 1'b1, 1'b0);
            else
                checkAll($sformatf("dn%0d.after", sel), sel, stAfter, 0, 1'b0, 1'b0, 1'b0);
            if (dropReq && m == 0) REQ_OFF = 1'b0;
        end
    endtask

    initial begin
        int k;
        int r;
        int lvl;

        #3;
        checkAll("reset", 0, 0, 0, 1'b0, 1'b0, 1'b0);
        checkAll("resetB", 1, 0, 0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        RST = 1'b0;

        $display("[TB] power-up");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int e = 1; e < SYNC + DEB; e++) begin
            tick();
            checkOutput($sformatf("pwrup.e%0d.state", e), 32'(stA), (e <= SYNC) ? 32'd0 : 32'd1);
            checkOutput($sformatf("pwrup.e%0d.grp", e), 32'(grpA), 32'd0);
        end
        tick();
        rampWalk(0, GAP, NG);

        r = $urandom_range(1, 5);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < r; i++) begin
            tick();
            checkAll("on.clrIgnored", 0, 3, NG, 1'b1, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);

        $display("[TB] shutdown");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        rampDownWalk(0, NG, GAP, 1'b0, 0);

        $display("[TB] debounce glitch");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (3) tick();
        checkAll("glitch.idle", 0, 0, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("glitch.e1", 32'(stA), 32'd0);
        tick();
        checkOutput("glitch.e2", 32'(stA), 32'd0);
        tick();
        checkOutput("glitch.e3", 32'(stA), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("glitch.e4", 32'(stA), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("glitch.e5", 32'(stA), 32'd1);
        tick();
        checkAll("glitch.drop", 0, 0, 0, 1'b0, 1'b0, 1'b0);
        for (int e = 7; e < 7 + DEB - 1; e++) begin
            tick();
            checkOutput($sformatf("redeb.e%0d.state", e), 32'(stA), 32'd1);
            checkOutput($sformatf("redeb.e%0d.grp", e), 32'(grpA), 32'd0);
        end
        tick();

        $display("[TB] abort ramp");
        k = $urandom_range(0, NG * GAP - 1);
        for (int n = 0; n <= k; n++) begin
            if (n > 0) tick();
            checkAll($sformatf("abort.n%0d", n), 0, 2, upLevel(n, GAP, NG), 1'b0, 1'b0, 1'b0);
        end
        lvl = upLevel(k, GAP, NG);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        rampDownWalk(0, lvl, GAP, 1'b1, 1);
        for (int e = 2; e < DEB; e++) begin
            tick();
            checkOutput("abort.redeb", 32'(stA), 32'd1);
        end
        tick();
        rampWalk(0, GAP, NG);

        $display("[TB] brown-out");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("bo.e1", 32'(stA), 32'd3);
        tick();
        checkOutput("bo.e2", 32'(stA), 32'd3);
        tick();
        checkAll("bo.e3", 0, 5, 0, 1'b0, 1'b0, 1'b1);
        checkAll("bo.e3B", 1, 5, 0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        r = $urandom_range(4, 8);
        for (int i = 0; i < r; i++) begin
            tick();
            checkAll("flt.hold", 0, 5, 0, 1'b0, 1'b0, 1'b1);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        checkAll("flt.clr", 0, 0, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int e = 1; e < DEB; e++) begin
            tick();
            checkOutput("flt.redeb", 32'(stA), 32'd1);
        end
        tick();
        for (int n = 0; n <= 3; n++) begin
            if (n > 0) tick();
            checkAll($sformatf("pre_rst.n%0d", n), 0, 2, upLevel(n, GAP, NG), 1'b0, 1'b0, 1'b0);
        end

        $display("[TB] async reset mid-ramp");
        #2;
        RST = 1'b1;
        #1;
        checkAll("arst", 0, 0, 0, 1'b0, 1'b0, 1'b0);
        checkAll("arstB", 1, 0, 0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checkAll("arst.hold", 0, 0, 0, 1'b0, 1'b0, 1'b0);
        RST = 1'b0;

        $display("[TB] N_GRP=1 STAGE_GAP=1 sweep");
        for (int e = 1; e < SYNC + DEB; e++) begin
            tick();
            checkOutput("sweep.deb", 32'(stB), (e <= SYNC) ? 32'd0 : 32'd1);
        end
        tick();
        rampWalk(1, 1, 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        rampDownWalk(1, 1, 1, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
